// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Instruction-sequencing state machine for the 16-bit programmable processor.
//   Sits between the instruction register and the datapath and turns the
//   current instruction word into per-cycle control strobes.
//
// Parameters
//   D_AW   data-memory address width
//   RF_AW  register-file address width
//
// Ports
//   Clk         in   system clock, rising-edge active
//   Reset       in   asynchronous, active-low reset
//   IR          in   current instruction word (opcode in IR[15:12])
//   PC_Clr      out  clear program counter
//   PC_Up       out  increment program counter
//   IR_Ld       out  load instruction register
//   D_Addr      out  data-memory address
//   D_Wr        out  data-memory write enable
//   RF_s        out  register-file write-data select (1 = memory, 0 = ALU)
//   RF_W_Addr   out  register-file write address
//   RF_W_en     out  register-file write enable
//   RF_Ra_Addr  out  register-file port A read address
//   RF_Rb_Addr  out  register-file port B read address
//   ALU_s0      out  ALU function (000 zero, 001 A+B, 010 A-B)
//   State       out  current state code
//   NextState   out  combinational next-state code
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int D_AW  = 8,
    parameter int RF_AW = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [15:0]      IR,
    output logic             PC_Clr,
    output logic             PC_Up,
    output logic             IR_Ld,
    output logic [D_AW-1:0]  D_Addr,
    output logic             D_Wr,
    output logic             RF_s,
    output logic [RF_AW-1:0] RF_W_Addr,
    output logic             RF_W_en,
    output logic [RF_AW-1:0] RF_Ra_Addr,
    output logic [RF_AW-1:0] RF_Rb_Addr,
    output logic [2:0]       ALU_s0,
    output logic [7:0]       State,
    output logic [7:0]       NextState
);

    typedef enum logic [7:0] {
        S_INIT   = 8'h00,
        S_FETCH  = 8'h01,
        S_DECODE = 8'h02,
        S_NOP    = 8'h03,
        S_LOADA  = 8'h04,
        S_LOADB  = 8'h05,
        S_STORE  = 8'h06,
        S_ADD    = 8'h07,
        S_SUB    = 8'h08,
        S_HALT   = 8'h09
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h6;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    state_t r_state;
    state_t w_next_state;

    // State register; reset forces Init immediately so write strobes drop at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; only Decode looks at the opcode.
    always_comb begin
        w_next_state = S_INIT;
        case (r_state)
            S_INIT:   w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    OP_STORE: w_next_state = S_STORE;
                    OP_LOAD:  w_next_state = S_LOADA;
                    OP_ADD:   w_next_state = S_ADD;
                    OP_SUB:   w_next_state = S_SUB;
                    OP_HALT:  w_next_state = S_HALT;
                    default:  w_next_state = S_NOP;   // reserved opcodes behave as NOOP
                endcase
            end
            S_LOADA:  w_next_state = S_LOADB;
            S_NOP:    w_next_state = S_FETCH;
            S_LOADB:  w_next_state = S_FETCH;
            S_STORE:  w_next_state = S_FETCH;
            S_ADD:    w_next_state = S_FETCH;
            S_SUB:    w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;      // only Reset leaves Halt
            default:  w_next_state = S_INIT;      // unused encodings recover
        endcase
    end

    // Moore output decode from the registered state; IR fields are re-sampled live.
    always_comb begin
        PC_Clr     = 1'b0;
        PC_Up      = 1'b0;
        IR_Ld      = 1'b0;
        D_Addr     = {D_AW{1'b0}};
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = {RF_AW{1'b0}};
        RF_W_en    = 1'b0;
        RF_Ra_Addr = {RF_AW{1'b0}};
        RF_Rb_Addr = {RF_AW{1'b0}};
        ALU_s0     = ALU_ZERO;
        case (r_state)
            S_INIT: begin
                PC_Clr = 1'b1;
            end
            S_FETCH: begin
                IR_Ld = 1'b1;
                PC_Up = 1'b1;
            end
            S_STORE: begin
                D_Addr     = D_AW'(IR[7:0]);
                RF_Ra_Addr = RF_AW'(IR[11:8]);
                D_Wr       = 1'b1;
            end
            S_LOADA: begin
                // Memory read latency cycle: address and mux set up, no write yet.
                D_Addr = D_AW'(IR[11:4]);
                RF_s   = 1'b1;
            end
            S_LOADB: begin
                D_Addr    = D_AW'(IR[11:4]);
                RF_s      = 1'b1;
                RF_W_Addr = RF_AW'(IR[3:0]);
                RF_W_en   = 1'b1;
            end
            S_ADD: begin
                RF_Ra_Addr = RF_AW'(IR[11:8]);
                RF_Rb_Addr = RF_AW'(IR[7:4]);
                RF_W_Addr  = RF_AW'(IR[3:0]);
                ALU_s0     = ALU_ADD;
                RF_W_en    = 1'b1;
            end
            S_SUB: begin
                RF_Ra_Addr = RF_AW'(IR[11:8]);
                RF_Rb_Addr = RF_AW'(IR[7:4]);
                RF_W_Addr  = RF_AW'(IR[3:0]);
                ALU_s0     = ALU_SUB;
                RF_W_en    = 1'b1;
            end
            default: begin
                // Decode, Nop, Halt and unused codes keep every strobe low.
                PC_Clr = 1'b0;
            end
        endcase
    end

    assign State     = r_state;
    assign NextState = w_next_state;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Randomized self-checking bench for control_unit. The reference model is a
//   per-instruction schedule: each instruction expands into the list of state
//   codes it must visit (Fetch, Decode, body...), and the expected strobes for
//   each state are derived from the instruction fields.
// -----------------------------------------------------------------------------
module tb_control_unit;

    localparam int D_AW  = 8;
    localparam int RF_AW = 4;

    logic             Clk;
    logic             Reset;
    logic [15:0]      IR;
    logic             PC_Clr;
    logic             PC_Up;
    logic             IR_Ld;
    logic [D_AW-1:0]  D_Addr;
    logic             D_Wr;
    logic             RF_s;
    logic [RF_AW-1:0] RF_W_Addr;
    logic             RF_W_en;
    logic [RF_AW-1:0] RF_Ra_Addr;
    logic [RF_AW-1:0] RF_Rb_Addr;
    logic [2:0]       ALU_s0;
    logic [7:0]       State;
    logic [7:0]       NextState;

    control_unit #(.D_AW(D_AW), .RF_AW(RF_AW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR         (IR),
        .PC_Clr     (PC_Clr),
        .PC_Up      (PC_Up),
        .IR_Ld      (IR_Ld),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .State      (State),
        .NextState  (NextState)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int total = 0;
    int bad   = 0;

    // Model state: current expected state code and upcoming state codes.
    int          cur_st;
    int          prev_st;
    int          sched[$];
    logic [15:0] prog[$];
    logic [15:0] pend_ir;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (model state %0h, IR %h): got %h expected %h", tag, cur_st, IR, got, exp);
        end
    endtask

    // Expand the next instruction into the states it must visit.
    task automatic load_next();
        logic [15:0] ins;
        logic [3:0]  op;
        if (prog.size() > 0) begin
            ins = prog.pop_front();
        end else begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h6) op = 4'h3;       // keep random traffic away from HALT
            ins = {op, 12'($urandom)};
        end
        pend_ir = ins;
        sched.push_back(1);
        sched.push_back(2);
        case (ins[15:12])
            4'h1: sched.push_back(6);
            4'h2: begin sched.push_back(4); sched.push_back(5); end
            4'h3: sched.push_back(7);
            4'h4: sched.push_back(8);
            4'h6: sched.push_back(9);
            default: sched.push_back(3);
        endcase
    endtask

    // Compare every DUT output against what the current model state implies.
    task automatic check_all();
        logic [15:0] iv;
        int          s;
        bit          is_ld, is_alu;
        iv     = IR;
        s      = cur_st;
        is_ld  = (s == 4) || (s == 5);
        is_alu = (s == 7) || (s == 8);
        check_val("State",      16'(State),      16'(s));
        check_val("NextState",  16'(NextState),  16'(sched[0]));
        check_val("PC_Clr",     16'(PC_Clr),     16'(s == 0));
        check_val("PC_Up",      16'(PC_Up),      16'(s == 1));
        check_val("IR_Ld",      16'(IR_Ld),      16'(s == 1));
        check_val("D_Wr",       16'(D_Wr),       16'(s == 6));
        check_val("RF_s",       16'(RF_s),       16'(is_ld));
        check_val("RF_W_en",    16'(RF_W_en),    16'((s == 5) || is_alu));
        check_val("D_Addr",     16'(D_Addr),
                  (s == 6) ? {8'h00, iv[7:0]} : (is_ld ? {8'h00, iv[11:4]} : 16'h0000));
        check_val("RF_W_Addr",  16'(RF_W_Addr),
                  ((s == 5) || is_alu) ? {12'h000, iv[3:0]} : 16'h0000);
        check_val("RF_Ra_Addr", 16'(RF_Ra_Addr),
                  ((s == 6) || is_alu) ? {12'h000, iv[11:8]} : 16'h0000);
        check_val("RF_Rb_Addr", 16'(RF_Rb_Addr), is_alu ? {12'h000, iv[7:4]} : 16'h0000);
        check_val("ALU_s0",     16'(ALU_s0),
                  (s == 7) ? 16'h0001 : ((s == 8) ? 16'h0002 : 16'h0000));
    endtask

    // One clock of model advance, IR-register emulation and checking.
    task automatic step();
        @(posedge Clk);
        #1;
        prev_st = cur_st;
        cur_st  = sched.pop_front();
        if (cur_st == 9) sched.push_front(9);   // Halt repeats until reset
        if (sched.size() == 0) load_next();
        if (prev_st == 1) begin
            IR = pend_ir;                       // IR register loads on the edge leaving Fetch
        end else if (cur_st == 3 || cur_st == 9) begin
            IR = 16'($urandom);                 // IR noise must not disturb sequencing
        end
        #1;
        check_all();
    endtask

    // Assert reset asynchronously, hold it for some edges, release at a falling edge.
    task automatic do_reset(input int cycles);
        Reset = 1'b0;
        #1;
        cur_st = 0;
        sched.delete();
        load_next();
        check_all();
        repeat (cycles) begin
            @(posedge Clk);
            #1;
            check_all();
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // Main sequence: directed program, random traffic, HALT, then mid-LoadB reset.
    initial begin
        int guard;
        IR    = 16'h0000;
        Reset = 1'b0;
        prog  = '{16'h2A13, 16'h3124, 16'h4124, 16'h15C0, 16'hF000, 16'h0000};
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'h6) op = 4'h2;
            prog.push_back({op, 12'($urandom)});
        end
        prog.push_back(16'h6000);

        do_reset(2);

        guard = 0;
        while (cur_st != 9 && guard < 3000) begin
            step();
            guard++;
        end
        check_val("halt_reached", 16'(cur_st == 9), 16'h0001);

        repeat (25) step();

        prog.delete();
        prog.push_back(16'h2A13);
        prog.push_back(16'h3124);
        do_reset(1);

        guard = 0;
        while (cur_st != 5 && guard < 20) begin
            step();
            guard++;
        end
        check_val("loadb_reached", 16'(cur_st == 5), 16'h0001);
        check_val("loadb_wen", 16'(RF_W_en), 16'h0001);

        // Abort inside LoadB: State and RF_W_en must drop before the next edge.
        do_reset(1);

        repeat (15) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing state machine for the 16-bit programmable processor. It sits between the instruction register and the datapath. It takes the current instruction word and drives:
- program-counter control,
- instruction-register load,
- data-memory address and write enable,
- register-file addresses and write enable,
- ALU select.

It also exports its current and next state codes for bench visibility.

## Interface
Parameters:
- D_AW, 8, data-memory address width
- RF_AW, 4, register-file address width

Ports:
- Clk  input  1  system clock, rising-edge active
- Reset  input  1  reset; asynchronous and active-low
- IR  input  16  current instruction from the instruction register
- PC_Clr  output  1  clear program counter
- PC_Up  output  1  increment program counter
- IR_Ld  output  1  load instruction register from instruction memory
- D_Addr  output  D_AW  data-memory address
- D_Wr  output  1  data-memory write enable
- RF_s  output  1  register-file write-data select: 1 = data memory, 0 = ALU
- RF_W_Addr  output  RF_AW  register-file write address
- RF_W_en  output  1  register-file write enable
- RF_Ra_Addr  output  RF_AW  register-file port A read address
- RF_Rb_Addr  output  RF_AW  register-file port B read address
- ALU_s0  output  3  ALU function: 000 pass zero, 001 A+B, 010 A−B
- State  output  8  current state code
- NextState  output  8  combinational next-state code

## Operation
- Opcode is IR[15:12]:
  - 0000 NOOP
  - 0001 STORE
  - 0010 LOAD
  - 0011 ADD
  - 0100 SUB
  - 0110 HALT
  - all other codes behave as NOOP
- Field layout:
  - STORE: ra = IR[11:8], addr = IR[7:0]
  - LOAD: addr = IR[11:4], rd = IR[3:0]
  - ADD/SUB: ra = IR[11:8], rb = IR[7:4], rd = IR[3:0]
- State codes:
  - Init 8'h00, Fetch 8'h01, Decode 8'h02, Nop 8'h03
  - LoadA 8'h04, LoadB 8'h05, Store 8'h06
  - Add 8'h07, Sub 8'h08, Halt 8'h09
- Transitions:
  - Init → Fetch; Fetch → Decode
  - Decode → Nop / Store / LoadA / Add / Sub / Halt, selected by opcode
  - LoadA → LoadB
  - Nop, LoadB, Store, Add, Sub → Fetch
  - Halt → Halt, until Reset is asserted
- Outputs are Moore: decoded from registered State plus IR fields. Every output not listed below is 0.
  - Init: PC_Clr=1
  - Fetch: IR_Ld=1, PC_Up=1
  - Decode, Nop, Halt: all zero
  - Store: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], D_Wr=1
  - LoadA: D_Addr=IR[11:4], RF_s=1 (memory read latency cycle; no write)
  - LoadB: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_en=1
  - Add: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], ALU_s0=001, RF_W_en=1
  - Sub: same as Add but ALU_s0=010
- NextState is purely combinational from State and IR[15:12]. It never drives outputs directly.
- Any unused state encoding recovers to Init on the next edge.

## Timing
- Reset low: State goes to Init immediately, without waiting for a clock edge.
- Reset values:
  - PC_Clr=1, State=8'h00, NextState=8'h01
  - all other outputs 0
- First rising edge after Reset goes high enters Fetch.
- IR is captured on the edge leaving Fetch. Decode therefore sees the new instruction.
- Per-instruction cost, measured from Fetch to the next Fetch:
  - NOOP, STORE, ADD, SUB: 3 cycles
  - LOAD: 4 cycles
- Register-file and data-memory writes take effect on the edge leaving the enabling state.
- Halt holds every enable at 0 indefinitely. PC does not advance.
- Reset asserted mid-instruction, in any state: abort to Init asynchronously. D_Wr and RF_W_en drop in the same instant, so no partial write occurs.
- IR changing while the machine is not in Decode has no effect on sequencing; fields are re-sampled combinationally in each state.

## Test plan
- Reset low 2 cycles, then high → State=00 with PC_Clr=1 during reset; Fetch (01) with IR_Ld=1 and PC_Up=1 on the first edge; Decode (02) on the next edge.
- IR=16'h2A13 (LOAD addr 0xA1 → R3) → states 01,02,04,05,01. D_Addr=0xA1 in 04 and 05; RF_W_en=1 and RF_W_Addr=3 only in 05; RF_s=1 in 04 and 05.
- IR=16'h3124 (ADD R1+R2 → R4) → state 07 for one cycle with ALU_s0=001, Ra=1, Rb=2, W_Addr=4, RF_W_en=1. IR=16'h4124 gives the same but ALU_s0=010 in state 08.
- IR=16'h15C0 (STORE R5 → 0xC0) → state 06 with D_Wr=1, D_Addr=0xC0, RF_Ra_Addr=5. RF_W_en stays 0.
- IR=16'hF000 (reserved opcode) → state 03, all enables 0, then back to 01. IR=16'h6000 (HALT) → state 09 held for 20+ cycles with PC_Up=0.
- Reset dropped while in LoadB with RF_W_en=1 → State=00 and RF_W_en=0 before the next clock edge. Normal Fetch resumes after release.
